control_fsm: RTL and testbench

- Top-level sequencer for the frame undistortion datapath.
- Per output pixel it fires single-cycle start pulses in order to five engines: coefficient calc -> xy_to_bram -> bram_reader -> interpolator -> bram_writer.
- Between pulses it waits for each engine's done pulse.
- It steps ROWS*COLS pixels per frame, then waits for the writer to drain and returns to idle.

---
 rtl/control_pkg.sv | 27 ++
 rtl/control_fsm_pixel_counter.sv | 67 ++++++
 rtl/control_fsm.sv | 86 ++++++++
 tb/tb_control_fsm.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared types and constants for the undistortion frame sequencer.
package control_pkg;

  localparam int unsigned DEF_ROWS     = 32'd240;
  localparam int unsigned DEF_COLS     = 32'd320;
  localparam int unsigned TOTAL_PIXELS = DEF_ROWS * DEF_COLS;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    S_COEFF = 4'd1,
    W_COEFF = 4'd2,
    S_XY    = 4'd3,
    W_XY    = 4'd4,
    S_RD    = 4'd5,
    W_RD    = 4'd6,
    S_INT   = 4'd7,
    W_INT   = 4'd8,
    S_WR    = 4'd9,
    W_WR    = 4'd10
  } state_e;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/control_fsm_pixel_counter.sv
// Modulo pixel counter with row/col debug counters and a last-pixel flag.
module pixel_counter
  import control_pkg::*;
#(
  parameter int unsigned ROWS = DEF_ROWS,
  parameter int unsigned COLS = DEF_COLS
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic last_o
);

  localparam int unsigned TOTAL = ROWS * COLS;
  localparam int unsigned PW    = cnt_width(TOTAL);
  localparam int unsigned RW    = cnt_width(ROWS);
  localparam int unsigned CW    = cnt_width(COLS);

  localparam logic [PW-1:0] PIX_LAST = PW'(TOTAL - 32'd1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 32'd1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 32'd1);

  logic [PW-1:0] pix_q, pix_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  // Next-count logic: clear wins over increment; all counters wrap together.
  always_comb begin
    pix_d = pix_q;
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      pix_d = '0;
      row_d = '0;
      col_d = '0;
    end else if (inc_i) begin
      pix_d = (pix_q == PIX_LAST) ? '0 : pix_q + PW'(1);
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
        row_d = row_q;
      end
    end else begin
      pix_d = pix_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_q <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      pix_q <= pix_d;
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  // Requiring row/col to agree with the linear count catches a corrupted counter.
  assign last_o = (pix_q == PIX_LAST) && (row_q == ROW_LAST) && (col_q == COL_LAST);

endmodule

// File: rtl/control_fsm.sv
// Frame sequencer: per pixel, pulses five engines in order and waits for each done.
module control_fsm
  import control_pkg::*;
#(
  parameter int unsigned ROWS = DEF_ROWS,
  parameter int unsigned COLS = DEF_COLS
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic coeff_done,
  input  logic xy_to_bram_done,
  input  logic bram_reader_done,
  input  logic interpolator_done,
  input  logic bram_writer_done,
  output logic start_coeff,
  output logic start_xy_to_bram,
  output logic start_bram_reader,
  output logic start_interpolator,
  output logic start_bram_writer
);

  state_e state_q, state_d;
  logic   last_s;
  logic   inc_s;
  logic   clr_s;

  pixel_counter #(.ROWS(ROWS), .COLS(COLS)) u_pix (
    .clk   (clk),
    .rst   (rst),
    .inc_i (inc_s),
    .clr_i (clr_s),
    .last_o(last_s)
  );

  // Next-state logic; each done input only matters in its own wait state.
  always_comb begin
    state_d = state_q;
    inc_s   = 1'b0;
    clr_s   = 1'b0;
    case (state_q)
      IDLE:    if (start)             state_d = S_COEFF; else state_d = IDLE;
      S_COEFF: state_d = W_COEFF;
      W_COEFF: if (coeff_done)        state_d = S_XY;    else state_d = W_COEFF;
      S_XY:    state_d = W_XY;
      W_XY:    if (xy_to_bram_done)   state_d = S_RD;    else state_d = W_XY;
      S_RD:    state_d = W_RD;
      W_RD:    if (bram_reader_done)  state_d = S_INT;   else state_d = W_RD;
      S_INT:   state_d = W_INT;
      W_INT:   if (interpolator_done) state_d = S_WR;    else state_d = W_INT;
      S_WR: begin
        inc_s   = 1'b1;
        state_d = last_s ? W_WR : S_COEFF;
      end
      W_WR: begin
        if (bram_writer_done) begin
          state_d = IDLE;
          clr_s   = 1'b1;
        end else begin
          state_d = W_WR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; pulses are decoded from the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q            <= IDLE;
      start_coeff        <= 1'b0;
      start_xy_to_bram   <= 1'b0;
      start_bram_reader  <= 1'b0;
      start_interpolator <= 1'b0;
      start_bram_writer  <= 1'b0;
    end else begin
      state_q            <= state_d;
      start_coeff        <= (state_d == S_COEFF);
      start_xy_to_bram   <= (state_d == S_XY);
      start_bram_reader  <= (state_d == S_RD);
      start_interpolator <= (state_d == S_INT);
      start_bram_writer  <= (state_d == S_WR);
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Randomised bench for control_fsm against a pulse/wait reference model.
module tb_control_fsm;

  localparam int ROWS  = 2;
  localparam int COLS  = 3;
  localparam int TOTAL = ROWS * COLS;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic coeff_done, xy_to_bram_done, bram_reader_done, interpolator_done, bram_writer_done;
  logic start_coeff, start_xy_to_bram, start_bram_reader, start_interpolator, start_bram_writer;

  control_fsm #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .coeff_done        (coeff_done),
    .xy_to_bram_done   (xy_to_bram_done),
    .bram_reader_done  (bram_reader_done),
    .interpolator_done (interpolator_done),
    .bram_writer_done  (bram_writer_done),
    .start_coeff       (start_coeff),
    .start_xy_to_bram  (start_xy_to_bram),
    .start_bram_reader (start_bram_reader),
    .start_interpolator(start_interpolator),
    .start_bram_writer (start_bram_writer)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: engine index 0..4 = coeff, xy, reader, interp, writer.
  bit m_active, m_drain;
  int m_pulse;   // engine being pulsed this cycle, -1 if none
  int m_wait;    // engine whose done is awaited, -1 if none
  int m_pix;     // pixels fully issued in this frame
  int frames = 0;
  int n_coeff, n_wr;
  int resp_eng = 0, resp_cnt = 0;

  function automatic logic [4:0] exp_vec();
    logic [4:0] v;
    v = 5'd0;
    if (m_pulse >= 0) v[m_pulse] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_drain = 1'b0; m_pulse = -1; m_wait = -1; m_pix = 0;
    n_coeff = 0; n_wr = 0; resp_cnt = 0;
  endtask

  task automatic model_step();
    logic [4:0] d;
    d = {bram_writer_done, interpolator_done, bram_reader_done, xy_to_bram_done, coeff_done};
    if (!rst) begin
      model_reset();
    end else if (!m_active) begin
      if (start) begin m_active = 1'b1; m_pulse = 0; m_pix = 0; end
    end else if (m_pulse >= 0) begin
      if (m_pulse == 4) begin
        m_pix++;
        m_drain = (m_pix == TOTAL);
        m_pulse = m_drain ? -1 : 0;
      end else begin
        m_wait = m_pulse; m_pulse = -1;
      end
    end else if (m_drain) begin
      if (d[4]) begin
        chk_eq("frame_coeff_pulses", n_coeff, TOTAL);
        chk_eq("frame_wr_pulses", n_wr, TOTAL);
        frames++;
        m_active = 1'b0; m_drain = 1'b0; m_pix = 0; n_coeff = 0; n_wr = 0;
      end
    end else if (d[m_wait]) begin
      m_pulse = m_wait + 1; m_wait = -1;
    end
  endtask

  task automatic tick();
    logic [4:0] outs;
    @(posedge clk);
    model_step();
    @(negedge clk);
    outs = {start_bram_writer, start_interpolator, start_bram_reader, start_xy_to_bram, start_coeff};
    chk_eq("start_outputs", 32'(outs), 32'(exp_vec()));
    if (outs[0]) n_coeff++;
    if (outs[4]) n_wr++;
  endtask

  // Engine responder: answer each pulse after lo..hi cycles, plus random noise pulses.
  task automatic drive(input int lo, input int hi, input int noise_pct, input bit allow_start);
    logic [4:0] d;
    d = 5'd0;
    if (m_pulse >= 0) begin
      resp_eng = m_pulse;
      resp_cnt = $urandom_range(hi, lo);
    end else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) d[resp_eng] = 1'b1;
    end
    for (int i = 0; i < 5; i++)
      if ($urandom_range(99, 0) < noise_pct) d[i] = 1'b1;
    start = allow_start && ($urandom_range(7, 0) == 0);
    {bram_writer_done, interpolator_done, bram_reader_done, xy_to_bram_done, coeff_done} = d;
  endtask

  initial begin
    int target;
    rst = 1'b0; start = 1'b0;
    {bram_writer_done, interpolator_done, bram_reader_done, xy_to_bram_done, coeff_done} = 5'd0;
    model_reset();

    // Reset held with random activity on every input.
    for (int i = 0; i < 6; i++) begin
      drive(1, 3, 40, 1);
      start = $urandom_range(1, 0);
      tick();
    end
    rst = 1'b1;
    start = 1'b1;
    {bram_writer_done, interpolator_done, bram_reader_done, xy_to_bram_done, coeff_done} = 5'd0;
    tick();

    // One clean frame with 10-cycle engine latency.
    target = 1;
    for (int i = 0; i < 3000 && frames < target; i++) begin drive(10, 10, 0, 0); tick(); end
    chk_eq("frame_a_done", frames, target);

    // Noisy frames: stray/out-of-order dones and starts while busy.
    target = frames + 4;
    for (int i = 0; i < 20000 && frames < target; i++) begin drive(1, 4, 15, 1); tick(); end
    chk_eq("frame_b_done", frames, target);

    // Let any frame finish, then run to W_RD of pixel 3 and reset there.
    for (int i = 0; i < 2000 && m_active; i++) begin drive(1, 3, 10, 0); tick(); end
    chk_eq("idle_before_reset_test", 32'(m_active), 32'd0);
    start = 1'b1;
    tick();
    for (int i = 0; i < 2000 && !(m_pix == 3 && m_wait == 2); i++) begin drive(2, 2, 0, 0); tick(); end
    chk_eq("reached_pix3_wrd", 32'(m_pix == 3 && m_wait == 2), 32'd1);
    rst = 1'b0;
    model_reset();
    #1;
    chk_eq("async_reset_outputs",
           32'({start_bram_writer, start_interpolator, start_bram_reader, start_xy_to_bram, start_coeff}),
           32'd0);
    for (int i = 0; i < 4; i++) begin drive(1, 3, 40, 1); tick(); end
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin drive(1, 3, 30, 0); tick(); end
    chk_eq("no_pulse_after_reset", n_coeff, 0);
    start = 1'b1;
    {bram_writer_done, interpolator_done, bram_reader_done, xy_to_bram_done, coeff_done} = 5'd0;
    tick();
    target = frames + 1;
    for (int i = 0; i < 3000 && frames < target; i++) begin drive(1, 3, 10, 0); tick(); end
    chk_eq("frame_c_done", frames, target);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
